// File: rtl/bin_to_decimal_2digit.sv
// bin_to_decimal_2digit
// Converts an unsigned 8-bit value into two registered BCD digits (tens, units)
// for the scoreboard display. Inputs above 99 saturate to "99".
// Latency is one clock. Reset is synchronous and active-high.

module bin_to_decimal_2digit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] bin_input,
  output logic [3:0] zehner,
  output logic [3:0] einer
);

  logic [6:0] value_clamped;
  logic [6:0] tens_times_ten;
  logic [3:0] zehner_d;
  logic [3:0] zehner_q;
  logic [3:0] einer_d;
  logic [3:0] einer_q;

  // Clamp to 0..99, pick the tens digit by range comparison, then derive units
  always_comb begin
    value_clamped  = (bin_input > 8'd99) ? 7'd99 : bin_input[6:0];
    zehner_d       = '0;
    for (int unsigned i = 1; i < 10; i++) begin
      if (value_clamped >= 7'(10 * i)) begin
        zehner_d = 4'(i);
      end
    end
    // 10*tens as 8*tens + 2*tens, so no multiplier is inferred
    tens_times_ten = 7'({zehner_d, 3'b000}) + 7'({zehner_d, 1'b0});
    einer_d        = 4'(value_clamped - tens_times_ten);
  end

  // Output digit registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zehner_q <= '0;
      einer_q  <= '0;
    end else begin
      zehner_q <= zehner_d;
      einer_q  <= einer_d;
    end
  end

  assign zehner = zehner_q;
  assign einer  = einer_q;

endmodule

// File: tb/tb_bin_to_decimal_2digit.sv
// Testbench for bin_to_decimal_2digit: directed vector table, exhaustive sweep,
// and randomized stimulus against a plain-arithmetic reference model.

module tb_bin_to_decimal_2digit;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] bin_input;
  logic [3:0] zehner;
  logic [3:0] einer;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic       rst;
    logic [7:0] bin;
    logic [3:0] exp_z;
    logic [3:0] exp_e;
    string      name;
  } vec_t;

  vec_t vecs[$];

  bin_to_decimal_2digit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bin_input (bin_input),
    .zehner    (zehner),
    .einer     (einer)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic r, input int b, input int z, input int e,
                              input string nm);
    vec_t v;
    v.rst   = r;
    v.bin   = 8'(b);
    v.exp_z = 4'(z);
    v.exp_e = 4'(e);
    v.name  = nm;
    return v;
  endfunction

  // Reference: reset clears, otherwise clamp to 99 and split with / and %
  function automatic void model(input logic r, input int b, output int z, output int e);
    int v;
    if (r) begin
      z = 0;
      e = 0;
    end else begin
      v = (b > 99) ? 99 : b;
      z = v / 10;
      e = v % 10;
    end
  endfunction

  task automatic check(input string nm, input int ez, input int ee);
    n_checks++;
    if (zehner !== 4'(ez) || einer !== 4'(ee)) begin
      n_fail++;
      $display("FAIL %s: got zehner=%0d einer=%0d, expected zehner=%0d einer=%0d",
               nm, zehner, einer, ez, ee);
    end
    n_checks++;
    if ($isunknown({zehner, einer}) || zehner > 4'd9 || einer > 4'd9) begin
      n_fail++;
      $display("FAIL %s_bcd: got zehner=%0d einer=%0d, expected both digits <= 9",
               nm, zehner, einer);
    end
  endtask

  // Drive inputs after the previous edge, sample #1 after the next edge
  task automatic step(input logic r, input int b);
    rst_i     = r;
    bin_input = 8'(b);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int ez, ee;
    int b;
    logic r;
    n_checks  = 0;
    n_fail    = 0;
    rst_i     = 1'b1;
    bin_input = 8'd0;

    vecs.push_back(mk(1'b1,   0, 0, 0, "reset_edge1"));
    vecs.push_back(mk(1'b1,   0, 0, 0, "reset_edge2"));
    vecs.push_back(mk(1'b0,   0, 0, 0, "dir_0"));
    vecs.push_back(mk(1'b0,   5, 0, 5, "dir_5"));
    vecs.push_back(mk(1'b0,  15, 1, 5, "dir_15"));
    vecs.push_back(mk(1'b0,  42, 4, 2, "dir_42"));
    vecs.push_back(mk(1'b1,  99, 0, 0, "mid_reset1"));
    vecs.push_back(mk(1'b1,  99, 0, 0, "mid_reset2"));
    vecs.push_back(mk(1'b0,  73, 7, 3, "release_73"));
    vecs.push_back(mk(1'b0,  99, 9, 9, "after_99"));
    vecs.push_back(mk(1'b0,   9, 0, 9, "bnd_9"));
    vecs.push_back(mk(1'b0,  10, 1, 0, "bnd_10"));
    vecs.push_back(mk(1'b0,  90, 9, 0, "bnd_90"));
    vecs.push_back(mk(1'b0,  99, 9, 9, "bnd_99"));
    vecs.push_back(mk(1'b0, 100, 9, 9, "sat_100"));
    vecs.push_back(mk(1'b0, 127, 9, 9, "sat_127"));
    vecs.push_back(mk(1'b0, 255, 9, 9, "sat_255"));
    vecs.push_back(mk(1'b0,   0, 0, 0, "sat_back_0"));
    vecs.push_back(mk(1'b0,  19, 1, 9, "dir_19"));
    vecs.push_back(mk(1'b0,  20, 2, 0, "dir_20"));

    foreach (vecs[i]) begin
      step(vecs[i].rst, int'(vecs[i].bin));
      check(vecs[i].name, int'(vecs[i].exp_z), int'(vecs[i].exp_e));
    end

    // Changes between edges must not disturb the registered outputs
    step(1'b0, 37);
    bin_input = 8'd81;
    #3;
    check("hold_between_edges", 3, 7);
    @(posedge clk_i);
    #1;
    check("after_mid_change", 8, 1);

    // Exhaustive sweep, back-to-back
    for (int v = 0; v < 256; v++) begin
      step(1'b0, v);
      model(1'b0, v, ez, ee);
      check("sweep", ez, ee);
    end

    // Randomized stimulus with occasional reset
    for (int k = 0; k < 400; k++) begin
      b = int'($urandom_range(0, 255));
      r = ($urandom_range(0, 15) == 0);
      step(r, b);
      model(r, b, ez, ee);
      check("random", ez, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
